// File: rtl/usb_rx_packet_ctrl.sv
// USB RX packet control: checks the SYNC byte after the serial-to-parallel stage,
// forwards payload bytes (PID onward) to the RX FIFO and flags packet-level errors.
module usb_rx_packet_ctrl #(
    parameter logic [7:0] SYNC_BYTE = 8'h80,
    parameter int         MAX_BYTES = 64,
    parameter int         COUNT_W   = 7
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               d_edge,
    input  logic               byte_received,
    input  logic [7:0]         rcv_data,
    input  logic               eop,
    input  logic               bit_pending,
    input  logic               fifo_full,
    output logic               rcving,
    output logic               w_enable,
    output logic [7:0]         data_out,
    output logic [COUNT_W-1:0] byte_count,
    output logic               r_error,
    output logic               packet_done
);

    localparam logic [COUNT_W-1:0] MAX_CNT = COUNT_W'(MAX_BYTES);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SYNC_WAIT = 2'd1,
        RECEIVE   = 2'd2,
        ERR_WAIT  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic               rcving_q, rcving_d;
    logic               w_enable_q, w_enable_d;
    logic [7:0]         data_out_q, data_out_d;
    logic [COUNT_W-1:0] byte_count_q, byte_count_d;
    logic               r_error_q, r_error_d;
    logic               packet_done_q, packet_done_d;

    // Count after this cycle's byte, so a simultaneous eop sees the updated value.
    logic [COUNT_W-1:0] count_next;
    logic               byte_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            rcving_q      <= 1'b0;
            w_enable_q    <= 1'b0;
            data_out_q    <= 8'h00;
            byte_count_q  <= '0;
            r_error_q     <= 1'b0;
            packet_done_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            rcving_q      <= rcving_d;
            w_enable_q    <= w_enable_d;
            data_out_q    <= data_out_d;
            byte_count_q  <= byte_count_d;
            r_error_q     <= r_error_d;
            packet_done_q <= packet_done_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        rcving_d      = rcving_q;
        w_enable_d    = 1'b0;
        data_out_d    = data_out_q;
        byte_count_d  = byte_count_q;
        r_error_d     = r_error_q;
        packet_done_d = 1'b0;
        count_next    = byte_count_q;
        byte_err      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (d_edge) begin
                    state_d      = SYNC_WAIT;
                    rcving_d     = 1'b1;
                    r_error_d    = 1'b0;
                    byte_count_d = '0;
                end
            end

            SYNC_WAIT: begin
                if (eop) begin
                    state_d   = IDLE;
                    rcving_d  = 1'b0;
                    r_error_d = 1'b1;
                end else if (byte_received) begin
                    if (rcv_data == SYNC_BYTE) begin
                        state_d = RECEIVE;
                    end else begin
                        state_d   = ERR_WAIT;
                        r_error_d = 1'b1;
                    end
                end
            end

            RECEIVE: begin
                if (byte_received) begin
                    if (fifo_full || (byte_count_q == MAX_CNT)) begin
                        byte_err  = 1'b1;
                        state_d   = ERR_WAIT;
                        r_error_d = 1'b1;
                    end else begin
                        count_next   = byte_count_q + COUNT_W'(1);
                        w_enable_d   = 1'b1;
                        data_out_d   = rcv_data;
                        byte_count_d = count_next;
                    end
                end
                // The byte is handled first; eop then closes the packet on the new count.
                if (eop) begin
                    state_d  = IDLE;
                    rcving_d = 1'b0;
                    if (!byte_err) begin
                        if (bit_pending || (count_next == '0)) begin
                            r_error_d = 1'b1;
                        end else begin
                            packet_done_d = 1'b1;
                        end
                    end
                end
            end

            ERR_WAIT: begin
                if (eop) begin
                    state_d  = IDLE;
                    rcving_d = 1'b0;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign rcving      = rcving_q;
    assign w_enable    = w_enable_q;
    assign data_out    = data_out_q;
    assign byte_count  = byte_count_q;
    assign r_error     = r_error_q;
    assign packet_done = packet_done_q;

endmodule

// File: tb/tb_usb_rx_packet_ctrl.sv
// Scoreboard bench for usb_rx_packet_ctrl: directed packets push expected writes/done
// pulses with their due cycle; a negedge monitor pops and compares them.
module tb_usb_rx_packet_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       d_edge = 1'b0;
    logic       byte_received = 1'b0;
    logic [7:0] rcv_data = 8'h00;
    logic       eop = 1'b0;
    logic       bit_pending = 1'b0;
    logic       fifo_full = 1'b0;

    logic       rcving_a, w_enable_a, r_error_a, packet_done_a;
    logic [7:0] data_out_a;
    logic [6:0] byte_count_a;
    logic       rcving_b, w_enable_b, r_error_b, packet_done_b;
    logic [7:0] data_out_b;
    logic [6:0] byte_count_b;

    // use_b selects the MAX_BYTES=2 instance for the oversize scenario.
    logic       use_b = 1'b0;
    logic       m_rcving, m_wen, m_err, m_done;
    logic [7:0] m_data;
    logic [6:0] m_cnt;

    assign m_rcving = use_b ? rcving_b      : rcving_a;
    assign m_wen    = use_b ? w_enable_b    : w_enable_a;
    assign m_err    = use_b ? r_error_b     : r_error_a;
    assign m_done   = use_b ? packet_done_b : packet_done_a;
    assign m_data   = use_b ? data_out_b    : data_out_a;
    assign m_cnt    = use_b ? byte_count_b  : byte_count_a;

    usb_rx_packet_ctrl dut (
        .clk(clk), .rst(rst), .d_edge(d_edge), .byte_received(byte_received),
        .rcv_data(rcv_data), .eop(eop), .bit_pending(bit_pending), .fifo_full(fifo_full),
        .rcving(rcving_a), .w_enable(w_enable_a), .data_out(data_out_a),
        .byte_count(byte_count_a), .r_error(r_error_a), .packet_done(packet_done_a)
    );

    usb_rx_packet_ctrl #(.MAX_BYTES(2)) dut_small (
        .clk(clk), .rst(rst), .d_edge(d_edge), .byte_received(byte_received),
        .rcv_data(rcv_data), .eop(eop), .bit_pending(bit_pending), .fifo_full(fifo_full),
        .rcving(rcving_b), .w_enable(w_enable_b), .data_out(data_out_b),
        .byte_count(byte_count_b), .r_error(r_error_b), .packet_done(packet_done_b)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit         is_done;
        logic [7:0] val;
        int         due;
    } exp_t;

    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Monitor: every write or done pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (m_wen) begin
            if (sbq.size() == 0) begin
                chk("unexpected_write", 32'(m_data), -1);
            end else begin
                e = sbq.pop_front();
                chk("write_kind", 32'(e.is_done), 0);
                chk("write_data", 32'(m_data), 32'(e.val));
                chk("write_cycle", cyc, e.due);
            end
        end
        if (m_done) begin
            if (sbq.size() == 0) begin
                chk("unexpected_done", 32'(m_cnt), -1);
            end else begin
                e = sbq.pop_front();
                chk("done_kind", 32'(e.is_done), 1);
                chk("done_count", 32'(m_cnt), 32'(e.val));
                chk("done_cycle", cyc, e.due);
            end
        end
    end

    // One clock: the current inputs are consumed at the edge, then pulses drop.
    task automatic tick();
        @(posedge clk);
        #1;
        d_edge = 1'b0;
        byte_received = 1'b0;
        eop = 1'b0;
        bit_pending = 1'b0;
    endtask

    task automatic push(input bit is_done, input logic [7:0] val);
        exp_t e;
        e.is_done = is_done;
        e.val = val;
        e.due = cyc;
        sbq.push_back(e);
    endtask

    task automatic start_pkt();
        d_edge = 1'b1;
        tick();
        rcv_data = 8'h80;
        byte_received = 1'b1;
        tick();
    endtask

    task automatic payload(input logic [7:0] b);
        rcv_data = b;
        byte_received = 1'b1;
        tick();
        push(1'b0, b);
    endtask

    task automatic drain(input string name);
        tick();
        chk(name, sbq.size(), 0);
    endtask

    initial begin
        // Reset state
        rst = 1'b1;
        rcv_data = 8'h5A;
        byte_received = 1'b1;
        tick();
        chk("rst_rcving", 32'(m_rcving), 0);
        chk("rst_wen", 32'(m_wen), 0);
        chk("rst_data", 32'(m_data), 0);
        chk("rst_count", 32'(m_cnt), 0);
        chk("rst_err", 32'(m_err), 0);
        chk("rst_done", 32'(m_done), 0);
        rst = 1'b0;
        tick();

        // 1: clean packet
        d_edge = 1'b1;
        tick();
        chk("t1_rcving", 32'(m_rcving), 1);
        chk("t1_err0", 32'(m_err), 0);
        rcv_data = 8'h80;
        byte_received = 1'b1;
        tick();
        chk("t1_sync_nowrite", 32'(m_wen), 0);
        payload(8'hC3);
        payload(8'hAA);
        payload(8'h55);
        eop = 1'b1;
        tick();
        push(1'b1, 8'd3);
        chk("t1_rcving_low", 32'(m_rcving), 0);
        chk("t1_err", 32'(m_err), 0);
        chk("t1_count", 32'(m_cnt), 3);
        drain("t1_queue_empty");

        // 2: bad sync, then next d_edge clears r_error
        d_edge = 1'b1;
        tick();
        rcv_data = 8'h81;
        byte_received = 1'b1;
        tick();
        chk("t2_err_set", 32'(m_err), 1);
        chk("t2_rcving", 32'(m_rcving), 1);
        rcv_data = 8'h11;
        byte_received = 1'b1;
        tick();
        rcv_data = 8'h22;
        byte_received = 1'b1;
        tick();
        eop = 1'b1;
        tick();
        chk("t2_rcving_low", 32'(m_rcving), 0);
        chk("t2_err_hold", 32'(m_err), 1);
        byte_received = 1'b1;
        tick();
        chk("t2_idle_ignore", 32'(m_rcving), 0);
        d_edge = 1'b1;
        tick();
        chk("t2_err_clear", 32'(m_err), 0);
        eop = 1'b1;
        tick();
        chk("t2_eop_in_sync", 32'(m_err), 1);
        chk("t2_eop_in_sync_rcv", 32'(m_rcving), 0);
        drain("t2_queue_empty");

        // 3: FIFO overrun
        start_pkt();
        payload(8'hC3);
        fifo_full = 1'b1;
        rcv_data = 8'h44;
        byte_received = 1'b1;
        tick();
        fifo_full = 1'b0;
        chk("t3_err", 32'(m_err), 1);
        chk("t3_rcving", 32'(m_rcving), 1);
        eop = 1'b1;
        tick();
        chk("t3_rcving_low", 32'(m_rcving), 0);
        chk("t3_count", 32'(m_cnt), 1);
        drain("t3_queue_empty");

        // 4: oversize on the MAX_BYTES=2 instance
        rst = 1'b1;
        tick();
        rst = 1'b0;
        use_b = 1'b1;
        start_pkt();
        payload(8'h01);
        payload(8'h02);
        rcv_data = 8'h03;
        byte_received = 1'b1;
        tick();
        chk("t4_err", 32'(m_err), 1);
        chk("t4_count", 32'(m_cnt), 2);
        eop = 1'b1;
        tick();
        chk("t4_rcving_low", 32'(m_rcving), 0);
        chk("t4_count_hold", 32'(m_cnt), 2);
        drain("t4_queue_empty");
        rst = 1'b1;
        tick();
        use_b = 1'b0;
        rst = 1'b0;
        tick();

        // 5a: eop with a partial byte pending
        start_pkt();
        payload(8'hC3);
        eop = 1'b1;
        bit_pending = 1'b1;
        tick();
        chk("t5a_err", 32'(m_err), 1);
        chk("t5a_rcving", 32'(m_rcving), 0);
        drain("t5a_queue_empty");

        // 5b: eop straight after sync
        start_pkt();
        eop = 1'b1;
        tick();
        chk("t5b_err", 32'(m_err), 1);
        chk("t5b_count", 32'(m_cnt), 0);
        drain("t5b_queue_empty");

        // 6: byte and eop together
        start_pkt();
        payload(8'h11);
        rcv_data = 8'h5A;
        byte_received = 1'b1;
        eop = 1'b1;
        tick();
        push(1'b0, 8'h5A);
        push(1'b1, 8'd2);
        chk("t6_count", 32'(m_cnt), 2);
        chk("t6_err", 32'(m_err), 0);
        chk("t6_rcving", 32'(m_rcving), 0);
        drain("t6_queue_empty");

        // 6b: reset mid-RECEIVE with a byte arriving on the same edge
        start_pkt();
        payload(8'h33);
        rst = 1'b1;
        rcv_data = 8'h44;
        byte_received = 1'b1;
        tick();
        chk("t6b_wen", 32'(m_wen), 0);
        chk("t6b_data", 32'(m_data), 0);
        chk("t6b_count", 32'(m_cnt), 0);
        chk("t6b_rcving", 32'(m_rcving), 0);
        chk("t6b_err", 32'(m_err), 0);
        chk("t6b_done", 32'(m_done), 0);
        rst = 1'b0;
        drain("t6b_queue_empty");
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/usb_rx_packet_ctrl.md
Name: usb_rx_packet_ctrl

Overview:
- Receiver control unit directly downstream of the USB RX 8-bit serial-to-parallel shift register.
- Consumes the assembled byte plus byte/EOP strobes from the RX timing logic.
- Validates the SYNC byte and forwards payload bytes (PID onward) to the RX FIFO with a registered write strobe.
- Flags sync, overrun, oversize and bit-alignment errors.

Parameters:
- SYNC_BYTE, 8'h80: expected first byte after LSB-first assembly.
- MAX_BYTES, 64: max payload bytes accepted per packet (1..127).
- COUNT_W, 7: width of byte_count.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- d_edge  in  1  one-cycle pulse: first line transition of a new packet.
- byte_received  in  1  one-cycle pulse: rcv_data holds a complete byte this cycle.
- rcv_data  in  8  parallel byte from the RX shift register.
- eop  in  1  one-cycle pulse: end-of-packet detected.
- bit_pending  in  1  high when the shift register holds a partial (1..7 bit) byte.
- fifo_full  in  1  RX FIFO cannot accept a write.
- rcving  out  1  packet in progress.
- w_enable  out  1  one-cycle FIFO write strobe.
- data_out  out  8  byte to write; valid while w_enable=1.
- byte_count  out  COUNT_W  payload bytes written this packet.
- r_error  out  1  sticky error flag for the last packet.
- packet_done  out  1  one-cycle pulse on clean packet end.

Behaviour:
- All outputs are registered. On rst=1 at a clk edge: state=IDLE, and every output is 0 (including data_out=8'h00 and byte_count=0). Reset mid-packet aborts it with no write or done pulse.
- IDLE:
  - On d_edge: go to SYNC_WAIT; next cycle rcving=1, r_error=0, byte_count=0.
  - byte_received and eop are ignored in IDLE.
- SYNC_WAIT:
  - byte_received with rcv_data==SYNC_BYTE: go to RECEIVE, no write.
  - byte_received with mismatch: go to ERR_WAIT, r_error=1.
  - eop (with or without byte_received): r_error=1, rcving=0, go to IDLE.
- RECEIVE, on byte_received:
  - If fifo_full=1 or byte_count==MAX_BYTES: go to ERR_WAIT, r_error=1, no write.
  - Otherwise: next cycle w_enable=1, data_out=rcv_data, byte_count+1.
- RECEIVE, on eop:
  - If bit_pending=1 or byte_count==0 (including a byte written in the same cycle): r_error=1, rcving=0, go to IDLE.
  - Otherwise: packet_done=1 for one cycle, rcving=0, go to IDLE.
- RECEIVE, byte_received and eop in the same cycle:
  - The byte is processed first (written, or error if full/oversize).
  - Then the eop rules apply using the updated count.
  - If the byte caused an error, go straight to IDLE with rcving=0, since eop is already seen.
- ERR_WAIT:
  - rcving=1, no writes, byte_received ignored.
  - On eop: rcving=0, go to IDLE. r_error stays 1.
- Output timing:
  - w_enable and packet_done are never high for more than one consecutive cycle per event.
  - w_enable lags byte_received by exactly 1 cycle.
  - rcving falls 1 cycle after eop.
- r_error holds until the next d_edge accepted in IDLE, or rst.
- d_edge is ignored outside IDLE.
- byte_count saturates by construction (never exceeds MAX_BYTES) and holds its final value until the next packet starts.

Test Plan:
1. Reset then clean packet: d_edge; bytes 8'h80, 8'hC3, 8'hAA, 8'h55; eop with bit_pending=0 -> three w_enable pulses with data_out C3/AA/55, each 1 cycle after its byte; byte_count=3; packet_done pulse 1 cycle after eop; rcving low; r_error=0.
2. Bad sync: d_edge; byte 8'h81; bytes 8'h11, 8'h22; eop -> r_error=1 from the cycle after 8'h81; no w_enable; rcving drops after eop; next d_edge clears r_error.
3. FIFO overrun: sync, 8'hC3 written, then fifo_full=1 with byte 8'h44, then eop -> only one write; r_error=1; no packet_done.
4. Oversize (MAX_BYTES=2): sync plus 3 payload bytes, then eop -> 2 writes, third dropped; r_error=1; byte_count=2.
5. Misaligned/empty EOP: (a) sync, 8'hC3, eop with bit_pending=1 -> r_error=1, no packet_done. (b) sync then eop immediately -> r_error=1.
6. Simultaneous events and reset: byte 8'h5A with eop in the same cycle after sync and one payload byte -> 8'h5A written, byte_count=2, packet_done asserted. Separately, rst asserted mid-RECEIVE -> all outputs 0 the next cycle and no pending w_enable.
